// File: rtl/cmn_demux_stream_buffered.sv
// Buffered val/rdy stream demux: routes each accepted message to one of
// noutputs streams, each output owning a one-entry pipe buffer so a stalled
// consumer only blocks traffic addressed to itself. Messages with an
// out-of-range select are consumed and counted in drop_count.
module cmn_demux_stream_buffered #(
    parameter int unsigned nbits    = 8,
    parameter int unsigned noutputs = 4,
    parameter int unsigned cbits    = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        recv_val,
    output logic                        recv_rdy,
    input  logic [nbits-1:0]            recv_msg,
    input  logic [$clog2(noutputs)-1:0] recv_sel,
    output logic                        send_val [0:noutputs-1],
    input  logic                        send_rdy [0:noutputs-1],
    output logic [nbits-1:0]            send_msg [0:noutputs-1],
    output logic [cbits-1:0]            drop_count
);

    localparam int unsigned sw = $clog2(noutputs);

    logic             full [0:noutputs-1];
    logic [nbits-1:0] data [0:noutputs-1];

    logic sel_ok;
    logic sel_full;
    logic sel_rdy;
    logic xfer;

    // Look up the addressed output's buffer state; an out-of-range or
    // unknown select matches no entry, so nothing indexes past the array.
    always_comb begin
        sel_full = 1'b0;
        sel_rdy  = 1'b0;
        for (int unsigned i = 0; i < noutputs; i++) begin
            if (recv_sel == sw'(i)) begin
                sel_full = full[i];
                sel_rdy  = send_rdy[i];
            end
        end
    end

    // Pipe-buffer ready: a full buffer still accepts if it drains this cycle;
    // invalid selects are always accepted so they can be dropped.
    always_comb begin
        sel_ok   = ({1'b0, recv_sel} < (sw + 1)'(noutputs));
        recv_rdy = !reset && (sel_ok ? (!sel_full || sel_rdy) : 1'b1);
        xfer     = recv_val && recv_rdy;
    end

    // Count messages consumed with an invalid select (wraps naturally).
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (xfer && !sel_ok) begin
            drop_count <= drop_count + cbits'(1);
        end
    end

    for (genvar g = 0; g < noutputs; g++) begin : g_out
        logic enq;
        logic deq;

        assign enq = xfer && sel_ok && (recv_sel == sw'(g));
        assign deq = full[g] && send_rdy[g];

        // One-entry buffer: simultaneous deq and enq refills in place.
        always_ff @(posedge clk) begin
            if (reset) begin
                full[g] <= 1'b0;
                data[g] <= '0;
            end else begin
                full[g] <= enq || (full[g] && !deq);
                if (enq) begin
                    data[g] <= recv_msg;
                end
            end
        end

        // Idle outputs drive zeros on the payload.
        always_comb begin
            send_val[g] = full[g];
            send_msg[g] = full[g] ? data[g] : '0;
        end
    end

endmodule

// File: tb/tb_cmn_demux_stream_buffered.sv
// Self-checking bench for cmn_demux_stream_buffered (3 outputs, 8-bit data,
// 8-bit drop counter) using per-output message queues as the reference.
module tb_cmn_demux_stream_buffered;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rv  = 1'b0;
    logic [1:0] rs  = 2'd0;
    logic [7:0] rm  = 8'h00;
    logic       sr [0:2];
    logic       rr;
    logic       sv [0:2];
    logic [7:0] sm [0:2];
    logic [7:0] dc;

    int checks = 0;
    int errors = 0;

    // Reference: each output is a FIFO of capacity one; drops are counted.
    logic [7:0] mq [3][$];
    int unsigned mdrop = 0;

    always #5 clk = ~clk;

    cmn_demux_stream_buffered #(.nbits(8), .noutputs(3), .cbits(8)) dut (
        .clk(clk), .reset(rst), .recv_val(rv), .recv_rdy(rr), .recv_msg(rm),
        .recv_sel(rs), .send_val(sv), .send_rdy(sr), .send_msg(sm),
        .drop_count(dc)
    );

    function automatic bit model_rdy();
        if (rst) return 1'b0;
        if (rs >= 2'd3) return 1'b1;
        return (mq[rs].size() == 0) || sr[rs];
    endfunction

    // Advance the reference by one clock edge, then move to the next negedge.
    task automatic cyc();
        bit acc;
        acc = !rst && rv && model_rdy();
        if (rst) begin
            for (int i = 0; i < 3; i++) mq[i].delete();
            mdrop = 0;
        end else begin
            for (int i = 0; i < 3; i++)
                if (mq[i].size() != 0 && sr[i]) void'(mq[i].pop_front());
            if (acc) begin
                if (rs < 2'd3) mq[rs].push_back(rm);
                else mdrop++;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; rv = 1'b0;
        for (int i = 0; i < 3; i++) sr[i] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (rr !== 1'b0) begin
                errors++;
                $display("FAIL reset_rdy cyc%0d: got %b want 0", k, rr);
            end
            cyc();
        end
        rst = 1'b0;
        #1;
        checks++;
        if (rr !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_rdy: got %b want 1", rr);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sv[i] !== 1'b0 || sm[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_out%0d: got val=%b msg=%h want 0/00", i, sv[i], sm[i]);
            end
        end
        checks++;
        if (dc !== 8'h00) begin
            errors++;
            $display("FAIL reset_drop: got %h want 00", dc);
        end
    endtask

    task automatic test_single();
        for (int i = 0; i < 3; i++) sr[i] = 1'b1;
        rv = 1'b1; rs = 2'd1; rm = 8'hA5;
        cyc();
        rv = 1'b0;
        checks++;
        if (sv[1] !== 1'b1 || sm[1] !== 8'hA5) begin
            errors++;
            $display("FAIL single_out1: got val=%b msg=%h want 1/a5", sv[1], sm[1]);
        end
        checks++;
        if (sv[0] !== 1'b0 || sm[0] !== 8'h00 || sv[2] !== 1'b0 || sm[2] !== 8'h00) begin
            errors++;
            $display("FAIL single_others: got %b/%h %b/%h want 0/00 0/00", sv[0], sm[0], sv[2], sm[2]);
        end
        cyc();
        checks++;
        if (sv[1] !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: got val=%b want 0", sv[1]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want;
        sr[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            want = 8'h10 + 8'(k);
            rv = 1'b1; rs = 2'd2; rm = want;
            #1;
            checks++;
            if (rr !== 1'b1) begin
                errors++;
                $display("FAIL b2b_rdy%0d: got %b want 1", k, rr);
            end
            cyc();
            checks++;
            if (sv[2] !== 1'b1 || sm[2] !== want) begin
                errors++;
                $display("FAIL b2b_out%0d: got val=%b msg=%h want 1/%h", k, sv[2], sm[2], want);
            end
        end
        rv = 1'b0;
        cyc();
    endtask

    task automatic test_stall();
        sr[0] = 1'b0; sr[1] = 1'b1; sr[2] = 1'b1;
        rv = 1'b1; rs = 2'd0; rm = 8'h01;
        cyc();
        rm = 8'h02;
        #1;
        checks++;
        if (rr !== 1'b0) begin
            errors++;
            $display("FAIL stall_rdy: got %b want 0", rr);
        end
        cyc();
        rs = 2'd1; rm = 8'h33;
        #1;
        checks++;
        if (rr !== 1'b1) begin
            errors++;
            $display("FAIL bypass_rdy: got %b want 1", rr);
        end
        cyc();
        checks++;
        if (sv[1] !== 1'b1 || sm[1] !== 8'h33 || sv[0] !== 1'b1 || sm[0] !== 8'h01) begin
            errors++;
            $display("FAIL bypass_out: got o1=%b/%h o0=%b/%h want 1/33 1/01", sv[1], sm[1], sv[0], sm[0]);
        end
        rs = 2'd0; rm = 8'h02; sr[0] = 1'b1;
        #1;
        checks++;
        if (rr !== 1'b1) begin
            errors++;
            $display("FAIL release_rdy: got %b want 1", rr);
        end
        cyc();
        rv = 1'b0;
        checks++;
        if (sv[0] !== 1'b1 || sm[0] !== 8'h02) begin
            errors++;
            $display("FAIL release_out: got val=%b msg=%h want 1/02", sv[0], sm[0]);
        end
        cyc();
        checks++;
        if (sv[0] !== 1'b0 || sv[1] !== 1'b0) begin
            errors++;
            $display("FAIL release_drain: got o0=%b o1=%b want 0 0", sv[0], sv[1]);
        end
    endtask

    task automatic test_drop();
        for (int i = 0; i < 3; i++) sr[i] = 1'b1;
        rv = 1'b1; rs = 2'd3; rm = 8'hFF;
        for (int k = 1; k <= 2; k++) begin
            #1;
            checks++;
            if (rr !== 1'b1) begin
                errors++;
                $display("FAIL drop_rdy%0d: got %b want 1", k, rr);
            end
            cyc();
            checks++;
            if (dc !== 8'(k) || sv[0] !== 1'b0 || sv[1] !== 1'b0 || sv[2] !== 1'b0) begin
                errors++;
                $display("FAIL drop_count%0d: got cnt=%h val=%b%b%b want %h 000", k, dc, sv[0], sv[1], sv[2], 8'(k));
            end
        end
        for (int k = 0; k < 253; k++) cyc();
        checks++;
        if (dc !== 8'hFF) begin
            errors++;
            $display("FAIL drop_preload: got %h want ff", dc);
        end
        cyc();
        rv = 1'b0;
        checks++;
        if (dc !== 8'h00) begin
            errors++;
            $display("FAIL drop_wrap: got %h want 00", dc);
        end
    endtask

    task automatic test_reset_flush();
        sr[0] = 1'b0; sr[1] = 1'b1; sr[2] = 1'b0;
        rv = 1'b1; rs = 2'd0; rm = 8'h44;
        cyc();
        rs = 2'd2; rm = 8'h66;
        cyc();
        checks++;
        if (sv[0] !== 1'b1 || sv[2] !== 1'b1) begin
            errors++;
            $display("FAIL flush_fill: got o0=%b o2=%b want 1 1", sv[0], sv[2]);
        end
        rst = 1'b1; rs = 2'd0; rm = 8'h77;
        #1;
        checks++;
        if (rr !== 1'b0) begin
            errors++;
            $display("FAIL flush_rdy: got %b want 0", rr);
        end
        cyc();
        rst = 1'b0; rv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (sv[i] !== 1'b0 || sm[i] !== 8'h00) begin
                errors++;
                $display("FAIL flush_out%0d: got val=%b msg=%h want 0/00", i, sv[i], sm[i]);
            end
        end
        checks++;
        if (dc !== 8'h00) begin
            errors++;
            $display("FAIL flush_drop: got %h want 00", dc);
        end
        cyc();
        checks++;
        if (sv[0] !== 1'b0) begin
            errors++;
            $display("FAIL flush_noaccept: got val=%b want 0", sv[0]);
        end
    endtask

    task automatic test_random();
        bit xsel;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            rv  = ($urandom_range(0, 3) != 0);
            rm  = 8'($urandom);
            rs  = 2'($urandom_range(0, 3));
            xsel = !rv && ($urandom_range(0, 3) == 0);
            if (xsel) rs = 2'bxx;
            for (int i = 0; i < 3; i++) sr[i] = ($urandom_range(0, 2) != 0);
            #1;
            if (!xsel) begin
                checks++;
                if (rr !== model_rdy()) begin
                    errors++;
                    $display("FAIL rand_rdy n=%0d: got %b want %b", n, rr, model_rdy());
                end
            end
            cyc();
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (sv[i] !== (mq[i].size() != 0) ||
                    sm[i] !== ((mq[i].size() != 0) ? mq[i][0] : 8'h00)) begin
                    errors++;
                    $display("FAIL rand_out%0d n=%0d: got val=%b msg=%h want val=%b msg=%h",
                             i, n, sv[i], sm[i], mq[i].size() != 0,
                             (mq[i].size() != 0) ? mq[i][0] : 8'h00);
                end
            end
            checks++;
            if (dc !== 8'(mdrop)) begin
                errors++;
                $display("FAIL rand_drop n=%0d: got %h want %h", n, dc, 8'(mdrop));
            end
        end
        rst = 1'b0; rv = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) sr[i] = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_drop();
        test_reset_flush();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
